// File: rtl/cpu_pkg.sv
// Shared opcodes, IR field positions and sequencer state encoding
// for the 32-bit RISC control unit.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  typedef enum logic [3:0] {
    RESET,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    HALTED
  } state_t;

  typedef enum logic [1:0] {
    K_NONE,
    K_ALU,
    K_MULDIV,
    K_HALT
  } kind_t;

  function automatic kind_t op_kind(input logic [4:0] op);
    kind_t k;
    k = K_NONE;
    unique case (1'b1)
      (op >= OP_ADD && op <= OP_ROL): k = K_ALU;
      (op == OP_MUL || op == OP_DIV): k = K_MULDIV;
      (op == OP_HALT):                k = K_HALT;
      default:                        k = K_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control strobes and status between the sequencer and the datapath;
// the sequencer side is master, the datapath side is slave.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        Mem_ready;
  logic        Stop;
  logic        PCout;
  logic        MDRout;
  logic        Zhighout;
  logic        Zlowout;
  logic        PCin;
  logic        MARin;
  logic        MDRin;
  logic        IRin;
  logic        Yin;
  logic        ZHighIn;
  logic        ZLowIn;
  logic        HIin;
  logic        LOin;
  logic        IncPC;
  logic        Read;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic [4:0]  ALU_op;
  logic        Run;

  modport master (
    input  IR, Mem_ready, Stop,
    output PCout, MDRout, Zhighout, Zlowout,
    output PCin, MARin, MDRin, IRin, Yin,
    output ZHighIn, ZLowIn, HIin, LOin,
    output IncPC, Read, Rout, Rin, ALU_op, Run
  );

  modport slave (
    output IR, Mem_ready, Stop,
    input  PCout, MDRout, Zhighout, Zlowout,
    input  PCin, MARin, MDRin, IRin, Yin,
    input  ZHighIn, ZLowIn, HIin, LOin,
    input  IncPC, Read, Rout, Rin, ALU_op, Run
  );
endinterface

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot register select with enable; all-zero when
// disabled.
module reg_select_decoder (
  input  logic        i_en,
  input  logic [3:0]  i_sel,
  output logic [15:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: Moore decode of state plus the
// opcode and register fields captured as the FSM leaves T2.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic                Clock,
  input  logic                Clear,
  control_sequencer_if.master bus
);

  state_t      r_state;
  state_t      w_next;
  state_t      w_t0;
  logic [4:0]  r_op;
  logic [3:0]  r_ra;
  logic [3:0]  r_rb;
  logic [3:0]  r_rc;
  kind_t       w_kind;

  logic        w_rout_en;
  logic [3:0]  w_rout_sel;
  logic        w_rin_en;
  logic [15:0] w_rout;
  logic [15:0] w_rin;

  assign w_kind = op_kind(r_op);

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) r_state <= RESET;
    else        r_state <= w_next;
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_op <= '0;
      r_ra <= '0;
      r_rb <= '0;
      r_rc <= '0;
    end else if (r_state == T2) begin
      r_op <= bus.IR[OPC_HI:OPC_LO];
      r_ra <= bus.IR[RA_HI:RA_LO];
      r_rb <= bus.IR[RB_HI:RB_LO];
      r_rc <= bus.IR[RC_HI:RC_LO];
    end
  end

  // A pending halt request replaces the return to T0.
  assign w_t0 = bus.Stop ? HALTED : T0;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RESET:  w_next = T0;
      T0:     w_next = T1;
      T1:     w_next = bus.Mem_ready ? T2 : T1;
      T2:     w_next = T3;
      T3: begin
        unique case (w_kind)
          K_ALU, K_MULDIV: w_next = T4;
          K_HALT:          w_next = HALTED;
          default:         w_next = w_t0;
        endcase
      end
      T4:     w_next = T5;
      T5:     w_next = (w_kind == K_MULDIV) ? T6 : w_t0;
      T6:     w_next = w_t0;
      HALTED: w_next = HALTED;
      default: w_next = RESET;
    endcase
  end

  always_comb begin
    bus.PCout    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.Zhighout = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.PCin     = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.ZHighIn  = 1'b0;
    bus.ZLowIn   = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.ALU_op   = 5'b00000;
    w_rout_en    = 1'b0;
    w_rout_sel   = 4'd0;
    w_rin_en     = 1'b0;
    unique case (r_state)
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
      end
      T1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        if (w_kind == K_ALU || w_kind == K_MULDIV) begin
          bus.Yin    = 1'b1;
          w_rout_en  = 1'b1;
          w_rout_sel = (w_kind == K_ALU) ? r_rb : r_ra;
        end
      end
      T4: begin
        if (w_kind == K_ALU || w_kind == K_MULDIV) begin
          bus.ALU_op  = r_op;
          bus.ZLowIn  = 1'b1;
          bus.ZHighIn = (w_kind == K_MULDIV);
          w_rout_en   = 1'b1;
          w_rout_sel  = (w_kind == K_ALU) ? r_rc : r_rb;
        end
      end
      T5: begin
        bus.Zlowout = 1'b1;
        bus.LOin    = (w_kind == K_MULDIV);
        w_rin_en    = (w_kind == K_ALU);
      end
      T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  reg_select_decoder u_rout_dec (
    .i_en     (w_rout_en),
    .i_sel    (w_rout_sel),
    .o_onehot (w_rout)
  );

  reg_select_decoder u_rin_dec (
    .i_en     (w_rin_en),
    .i_sel    (r_ra),
    .o_onehot (w_rin)
  );

  assign bus.Rout = w_rout;
  assign bus.Rin  = w_rin;
  assign bus.Run  = (r_state != RESET) && (r_state != HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector bench for control_sequencer: per-cycle table of
// inputs and expected strobes, plus async-reset and stall sequences.
module tb_control_sequencer;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  control_sequencer_if bus ();

  control_sequencer dut (
    .Clock (clk),
    .Clear (clr),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag word: PCout MDRout Zhighout Zlowout PCin MARin MDRin IRin
  //            Yin ZHighIn ZLowIn HIin LOin IncPC Read Run
  localparam logic [15:0] F_0   = 16'h0000;
  localparam logic [15:0] F_T0  = 16'h8405;
  localparam logic [15:0] F_T1  = 16'h0203;
  localparam logic [15:0] F_T2  = 16'h4101;
  localparam logic [15:0] F_Y   = 16'h0081;
  localparam logic [15:0] F_ZL  = 16'h0021;
  localparam logic [15:0] F_WB  = 16'h1001;
  localparam logic [15:0] F_MT4 = 16'h0061;
  localparam logic [15:0] F_LO  = 16'h1009;
  localparam logic [15:0] F_HI  = 16'h2011;
  localparam logic [15:0] F_RUN = 16'h0001;

  localparam logic [31:0] IR_ADD  = 32'h1A1B8000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_MUL  = 32'h79280000;
  localparam logic [31:0] IR_UND  = 32'hF8000000;
  localparam logic [31:0] IR_SUB  = 32'h20048000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  typedef struct {
    logic        clr;
    logic [31:0] ir;
    logic        mr;
    logic        stop;
    logic [15:0] flags;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  op;
  } vec_t;

  vec_t tbl[64];
  int   ntbl;

  function automatic logic [52:0] actual();
    return {bus.PCout, bus.MDRout, bus.Zhighout, bus.Zlowout,
            bus.PCin, bus.MARin, bus.MDRin, bus.IRin,
            bus.Yin, bus.ZHighIn, bus.ZLowIn, bus.HIin,
            bus.LOin, bus.IncPC, bus.Read, bus.Run,
            bus.Rout, bus.Rin, bus.ALU_op};
  endfunction

  task automatic chk(input string nm, input logic [52:0] act,
                     input logic [52:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got flags=%h rout=%h rin=%h op=%h, want flags=%h rout=%h rin=%h op=%h",
               nm, act[52:37], act[36:21], act[20:5], act[4:0],
               exp[52:37], exp[36:21], exp[20:5], exp[4:0]);
    end
  endtask

  task automatic add(input logic c, input logic [31:0] ir,
                     input logic mr, input logic st,
                     input logic [15:0] f, input logic [15:0] ro,
                     input logic [15:0] ri, input logic [4:0] op);
    tbl[ntbl] = '{c, ir, mr, st, f, ro, ri, op};
    ntbl++;
  endtask

  initial begin
    int cyc;
    int n;
    checks = 0;
    errors = 0;
    ntbl   = 0;
    clr           = 1'b0;
    bus.IR        = '0;
    bus.Mem_ready = 1'b1;
    bus.Stop      = 1'b0;

    // reset for 3 cycles, then first fetch
    add(0, IR_ADD, 1, 0, F_0,   16'h0, 16'h0, 5'd0);
    add(0, IR_ADD, 1, 0, F_0,   16'h0, 16'h0, 5'd0);
    add(0, IR_ADD, 1, 0, F_0,   16'h0, 16'h0, 5'd0);
    add(1, IR_ADD, 1, 0, F_T0,  16'h0, 16'h0, 5'd0);
    // add R4,R3,R7
    add(1, IR_ADD, 1, 0, F_T1,  16'h0, 16'h0, 5'd0);
    add(1, IR_ADD, 1, 0, F_T2,  16'h0, 16'h0, 5'd0);
    add(1, IR_ADD, 1, 0, F_Y,   16'h0008, 16'h0, 5'd0);
    add(1, IR_ADD, 1, 0, F_ZL,  16'h0080, 16'h0, 5'h03);
    add(1, IR_ADD, 1, 0, F_WB,  16'h0, 16'h0010, 5'd0);
    add(1, IR_ADD, 1, 0, F_T0,  16'h0, 16'h0, 5'd0);
    // memory stall on a NOP fetch
    add(1, IR_NOP, 0, 0, F_T1,  16'h0, 16'h0, 5'd0);
    add(1, IR_NOP, 0, 0, F_T1,  16'h0, 16'h0, 5'd0);
    add(1, IR_NOP, 0, 0, F_T1,  16'h0, 16'h0, 5'd0);
    add(1, IR_NOP, 0, 0, F_T1,  16'h0, 16'h0, 5'd0);
    add(1, IR_NOP, 1, 0, F_T2,  16'h0, 16'h0, 5'd0);
    add(1, IR_NOP, 1, 0, F_RUN, 16'h0, 16'h0, 5'd0);
    add(1, IR_NOP, 1, 0, F_T0,  16'h0, 16'h0, 5'd0);
    // MUL Ra=2 Rb=5
    add(1, IR_MUL, 1, 0, F_T1,  16'h0, 16'h0, 5'd0);
    add(1, IR_MUL, 1, 0, F_T2,  16'h0, 16'h0, 5'd0);
    add(1, IR_MUL, 1, 0, F_Y,   16'h0004, 16'h0, 5'd0);
    add(1, IR_MUL, 1, 0, F_MT4, 16'h0020, 16'h0, 5'h0F);
    add(1, IR_MUL, 1, 0, F_LO,  16'h0, 16'h0, 5'd0);
    add(1, IR_MUL, 1, 0, F_HI,  16'h0, 16'h0, 5'd0);
    add(1, IR_MUL, 1, 0, F_T0,  16'h0, 16'h0, 5'd0);
    // undefined opcode behaves as NOP
    add(1, IR_UND, 1, 0, F_T1,  16'h0, 16'h0, 5'd0);
    add(1, IR_UND, 1, 0, F_T2,  16'h0, 16'h0, 5'd0);
    add(1, IR_UND, 1, 0, F_RUN, 16'h0, 16'h0, 5'd0);
    add(1, IR_UND, 1, 0, F_T0,  16'h0, 16'h0, 5'd0);
    // sub R0,R0,R9 then Stop at end
    add(1, IR_SUB, 1, 0, F_T1,  16'h0, 16'h0, 5'd0);
    add(1, IR_SUB, 1, 0, F_T2,  16'h0, 16'h0, 5'd0);
    add(1, IR_SUB, 1, 0, F_Y,   16'h0001, 16'h0, 5'd0);
    add(1, IR_SUB, 1, 0, F_ZL,  16'h0200, 16'h0, 5'h04);
    add(1, IR_SUB, 1, 0, F_WB,  16'h0, 16'h0001, 5'd0);
    add(1, IR_SUB, 1, 1, F_0,   16'h0, 16'h0, 5'd0);
    add(1, IR_SUB, 1, 0, F_0,   16'h0, 16'h0, 5'd0);
    add(0, IR_HALT, 1, 0, F_0,  16'h0, 16'h0, 5'd0);
    add(1, IR_HALT, 1, 0, F_T0, 16'h0, 16'h0, 5'd0);
    // HALT opcode
    add(1, IR_HALT, 1, 0, F_T1, 16'h0, 16'h0, 5'd0);
    add(1, IR_HALT, 1, 0, F_T2, 16'h0, 16'h0, 5'd0);
    add(1, IR_HALT, 1, 0, F_RUN, 16'h0, 16'h0, 5'd0);
    add(1, IR_HALT, 1, 0, F_0,  16'h0, 16'h0, 5'd0);
    add(1, IR_HALT, 1, 0, F_0,  16'h0, 16'h0, 5'd0);
    add(0, IR_ADD, 1, 0, F_0,   16'h0, 16'h0, 5'd0);
    add(1, IR_ADD, 1, 0, F_T0,  16'h0, 16'h0, 5'd0);

    #1;
    chk("reset_t0", actual(), 53'd0);

    for (int i = 0; i < ntbl; i++) begin
      @(negedge clk);
      clr           = tbl[i].clr;
      bus.IR        = tbl[i].ir;
      bus.Mem_ready = tbl[i].mr;
      bus.Stop      = tbl[i].stop;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), actual(),
          {tbl[i].flags, tbl[i].rout, tbl[i].rin, tbl[i].op});
    end

    // async reset while in T4 of an ADD
    @(negedge clk);
    bus.IR        = IR_ADD;
    bus.Mem_ready = 1'b1;
    bus.Stop      = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_async_t4", actual(), {F_ZL, 16'h0080, 16'h0, 5'h03});
    #2;
    clr = 1'b0;
    #1;
    chk("async_clear", actual(), 53'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_t0", actual(), {F_T0, 16'h0, 16'h0, 5'd0});

    // random-length stall, bounded wait for IRin
    n = $urandom_range(1, 5);
    @(negedge clk);
    bus.IR        = IR_NOP;
    bus.Mem_ready = 1'b0;
    for (int k = 0; k <= n; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d", k), actual(),
          {F_T1, 16'h0, 16'h0, 5'd0});
    end
    @(negedge clk);
    bus.Mem_ready = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.IRin) break;
    end
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL stall_release: IRin after %0d cycles, want 1", cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit RISC datapath. It drives the strobes that the datapath's unit benches currently toggle by hand: bus source selects, register loads, ALU op, and memory read. It fetches an instruction through the PC/MAR/MDR path, latches IR fields, and sequences execution of register-format ALU, MUL/DIV, NOP and HALT instructions. It sits beside `DataPath` and connects to its control inputs one-to-one.

## Interface
- No parameters.
- `Clock` in 1: system clock, rising-edge.
- `Clear` in 1: asynchronous, active-low reset.
- `IR` in 32: datapath IR contents. Fields are opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- `Mem_ready` in 1: memory has driven Mdatain and the MDR may capture it. Sampled in T1.
- `Stop` in 1: halt request, sampled at T0 entry.
- `PCout`, `MDRout`, `Zhighout`, `Zlowout` out 1 each: bus drivers.
- `PCin`, `MARin`, `MDRin`, `IRin`, `Yin`, `ZHighIn`, `ZLowIn`, `HIin`, `LOin`, `IncPC`, `Read` out 1 each: loads and strobes.
- `Rout` out 16: one-hot register-to-bus select for R0–R15.
- `Rin` out 16: one-hot register load for R0–R15.
- `ALU_op` out 5: ALU operation code.
- `Run` out 1: high while executing, low in reset and HALTED.

## Operation
- States: RESET, T0, T1, T2, T3, T4, T5, T6, HALTED.
- All outputs are a Moore decode of state plus the Ra/Rb/Rc/opcode fields latched at T2→T3.
- At most one bus driver is active in any state.
- **Fetch:**
  - T0: PCout, MARin, IncPC.
  - T1: Read, MDRin. The FSM stays in T1 while `Mem_ready`=0 and advances on the edge where it is 1.
  - T2: MDRout, IRin. Opcode and register fields are latched from `IR` on the T2→T3 edge.
- **ALU format** (opcodes 00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 00111 SHR, 01000 SHL, 01001 ROR, 01010 ROL):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], ALU_op=opcode, ZLowIn.
  - T5: Zlowout, Rin[Ra].
  - Then T0.
  - The result is Z = Y op bus, which is Rb op Rc.
- **MUL 01111 / DIV 10000:**
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], ALU_op=opcode, ZHighIn, ZLowIn.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Then T0.
- **NOP 11010 and any undefined opcode:** T3 asserts nothing, then T0.
- **HALT 11011:** T3→HALTED.
- **Stop:** if `Stop`=1 at the T0 entry edge, the next state is HALTED instead of T0. HALTED holds until reset.
- `ALU_op` is 00000 outside T4.

## Timing
- Reset: while `Clear`=0, state is RESET and every output is 0, including `Rout`, `Rin`, `ALU_op` and `Run`. On the first rising edge with `Clear`=1 the state goes to T0.
- `Clear` asserted mid-instruction forces RESET immediately and asynchronously, and all strobes drop in the same instant.
- Latency with `Mem_ready` tied high:
  - ALU instruction: 6 cycles, T0–T5.
  - MUL/DIV: 7 cycles.
  - NOP: 4 cycles.
- Each cycle of `Mem_ready`=0 in T1 adds one cycle. During the stall Read and MDRin stay high and no other strobe is active.
- Register writes target Ra even when Ra=Rb or Ra=Rc. Y is loaded in T3, before the write in T5, so self-referencing operands are read correctly.
- Rin[0] is asserted for Ra=0; zero-register semantics belong to the datapath.
- `Run` is 1 in T0–T6 and 0 in RESET and HALTED.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants: ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, MUL, DIV, NOP, HALT;
  - state enum;
  - IR field bit positions.
- Sub-module `reg_select_decoder`: 4-to-16 one-hot decoder with an enable. It is instantiated twice, once for `Rout` and once for `Rin`.
- The FSM, the field latch and the output decode live in `control_sequencer`.

## Test plan
1. **Reset and first fetch:** hold `Clear`=0 for 3 cycles, then release. Require all outputs 0 during reset, then T0 with PCout=MARin=IncPC=1 and `Run`=1.
2. **ADD fetch/execute:** IR=0x1A1B8000 (add R4,R3,R7), `Mem_ready`=1.
   - T3: Rout=0x0008 with Yin=1.
   - T4: Rout=0x0080, ALU_op=00011, ZLowIn=1.
   - T5: Zlowout=1, Rin=0x0010.
   - Back to T0 after 6 cycles.
3. **Memory stall:** hold `Mem_ready`=0 for 3 cycles in T1. Require Read=MDRin=1 throughout, no IRin, and T2 reached on the 4th cycle.
4. **MUL:** IR opcode 01111 with Ra=2, Rb=5. Require Rout=0x0004 with Yin, then Rout=0x0020 with ZHighIn=ZLowIn=1, then LOin, then HIin. Total 7 cycles.
5. **HALT and Stop:**
   - Opcode 11011 leads to HALTED with `Run`=0 and all strobes 0.
   - Separately, `Stop`=1 at the end of an ADD leads to HALTED instead of T0.
6. **Async reset mid-T4:** drop `Clear` between edges. Require ZLowIn and `Rout` to go 0 immediately and the sequence to restart at T0 after release.
